idct_mul_seq_ctrl: RTL

IDCT_MUL_SEQ_CTRL -- requirements
Module: idct_mul_seq_ctrl

---
 rtl/idct_mul_pkg.sv | 46 ++++
 rtl/idct_mul_opbuf.sv | 38 +++
 rtl/idct_mul_seq_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/idct_mul_pkg.sv
// Shared types, codes and sizing for the IDCT multiplier sequencer.
// Optional approximate-path control via macro MUL_CTRL_APX_EN.
package idct_mul_pkg;

  localparam int BLK_LEN_DEF = 64;
  localparam int DP_W_DEF    = 26;
  localparam int B_W_OFF     = 11;
  localparam int P_W         = 32;
  localparam int ST_W        = 3;
  localparam int CNT0_W      = 9;
  localparam int TAG_DEPTH   = 3;
  localparam int DRAIN_CYC   = TAG_DEPTH;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE    = 3'b000,
    ST_PRIME   = 3'b001,
    ST_PASS_LO = 3'b010,
    ST_PASS_HI = 3'b011,
    ST_DRAIN   = 3'b100
  } state_e;

  typedef struct packed {
    logic in_rdy;
    logic acc_sel;
    logic rapx;
  } ctl_t;

  // Control outputs are loaded together with the state so they align with state_in_to_wrapper.
  function automatic ctl_t ctl_for(state_e s);
    ctl_t c;
    c.in_rdy = (s == ST_PRIME);
`ifdef MUL_CTRL_APX_EN
    c.acc_sel = (s != ST_PASS_LO);
    c.rapx    = (s == ST_PASS_HI);
`else
    c.acc_sel = 1'b1;
    c.rapx    = 1'b0;
`endif
    return c;
  endfunction

  function automatic logic is_pass(state_e s);
    return (s == ST_PASS_LO) || (s == ST_PASS_HI);
  endfunction

endpackage

// File: rtl/idct_mul_opbuf.sv
// Operand-pair buffer: one write port, one registered read port whose output
// register clears to zero when no read is requested.
module idct_mul_opbuf #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 41
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_dat,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_dat
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_dat;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_dat;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_dat <= '0;
    end else if (i_rd_en) begin
      r_rd_dat <= r_mem[i_rd_addr];
    end else begin
      r_rd_dat <= '0;
    end
  end

  assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/idct_mul_seq_ctrl.sv
// Sequencer feeding a block of operand pairs twice (LO/HI pass) through a multiplier wrapper;
// results emerge 3 cycles after operand presentation with no backpressure. Macro: MUL_CTRL_APX_EN.
module idct_mul_seq_ctrl
  import idct_mul_pkg::*;
#(
  parameter int DATA_PATH_BITWIDTH = DP_W_DEF,
  parameter int BLK_LEN            = BLK_LEN_DEF
) (
  input  logic                                    clk,
  input  logic                                    rstN,
  input  logic                                    start,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0]           in_a,
  input  logic [DATA_PATH_BITWIDTH-B_W_OFF-1:0]   in_b,
  output logic [DATA_PATH_BITWIDTH-1:0]           A_in_to_wrapper,
  output logic [DATA_PATH_BITWIDTH-B_W_OFF-1:0]   B_in_to_wrapper,
  output logic [ST_W-1:0]                         state_in_to_wrapper,
  output logic [CNT0_W-1:0]                       count0,
  output logic                                    acc__sel,
  output logic                                    racc,
  output logic                                    rapx,
  input  logic [ST_W-1:0]                         state_out_of_wrapper,
  input  logic [P_W-1:0]                          P,
  output logic                                    res_valid,
  output logic [$clog2(BLK_LEN)-1:0]              res_idx,
  output logic                                    res_pass,
  output logic [P_W-1:0]                          res_data,
  output logic                                    done
);

  localparam int A_W   = DATA_PATH_BITWIDTH;
  localparam int B_W   = DATA_PATH_BITWIDTH - B_W_OFF;
  localparam int IDX_W = $clog2(BLK_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(BLK_LEN - 1);
  localparam logic [1:0]       DRAIN_LAST = 2'(DRAIN_CYC - 1);

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
    logic             pass;
  } tag_t;

  state_e             r_state;
  state_e             r_state_d;
  ctl_t               r_ctl;
  logic [IDX_W-1:0]   r_cnt;
  logic [1:0]         r_drain_cnt;
  logic               r_done;
  logic               r_racc;
  logic [CNT0_W-1:0]  r_count0;
  tag_t               r_pres;
  tag_t               r_tag [TAG_DEPTH];
  logic [P_W-1:0]     r_p;

  logic               w_accept;
  logic               w_desync;
  logic               w_rd_en;
  logic [A_W+B_W-1:0] w_rd_dat;

  assign w_accept = r_ctl.in_rdy & in_valid;
  // The wrapper echoes last cycle's state; any other value means it lost sync with us.
  assign w_desync = is_pass(r_state_d) && (state_out_of_wrapper != r_state_d);
  assign w_rd_en  = is_pass(r_state) && !w_desync;

  idct_mul_opbuf #(
    .DEPTH (BLK_LEN),
    .WIDTH (A_W + B_W)
  ) u_opbuf (
    .i_clk     (clk),
    .i_rst_n   (rstN),
    .i_wr_en   (w_accept),
    .i_wr_addr (r_cnt),
    .i_wr_dat  ({in_a, in_b}),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_cnt),
    .o_rd_dat  (w_rd_dat)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state     <= ST_IDLE;
      r_ctl       <= ctl_for(ST_IDLE);
      r_cnt       <= '0;
      r_drain_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_desync) begin
        r_state     <= ST_IDLE;
        r_ctl       <= ctl_for(ST_IDLE);
        r_cnt       <= '0;
        r_drain_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state <= ST_PRIME;
              r_ctl   <= ctl_for(ST_PRIME);
              r_cnt   <= '0;
            end
          end
          ST_PRIME: begin
            if (w_accept) begin
              if (r_cnt == LAST_IDX) begin
                r_cnt   <= '0;
                r_state <= ST_PASS_LO;
                r_ctl   <= ctl_for(ST_PASS_LO);
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          ST_PASS_LO: begin
            if (r_cnt == LAST_IDX) begin
              r_cnt   <= '0;
              r_state <= ST_PASS_HI;
              r_ctl   <= ctl_for(ST_PASS_HI);
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_PASS_HI: begin
            if (r_cnt == LAST_IDX) begin
              r_cnt       <= '0;
              r_drain_cnt <= '0;
              r_state     <= ST_DRAIN;
              r_ctl       <= ctl_for(ST_DRAIN);
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_DRAIN: begin
            // done lands with the last result, which leaves the tag pipe as we return to IDLE.
            if (r_drain_cnt == DRAIN_LAST) begin
              r_drain_cnt <= '0;
              r_done      <= 1'b1;
              r_state     <= ST_IDLE;
              r_ctl       <= ctl_for(ST_IDLE);
            end else begin
              r_drain_cnt <= r_drain_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_ctl   <= ctl_for(ST_IDLE);
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state_d <= ST_IDLE;
      r_count0  <= '0;
      r_racc    <= 1'b1;
      r_p       <= '0;
      r_pres    <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_racc    <= 1'b0;
      r_state_d <= w_desync ? ST_IDLE : r_state;
      r_count0  <= CNT0_W'(r_cnt);
      r_p       <= P;
      if (w_desync) begin
        r_pres <= '0;
        for (int i = 0; i < TAG_DEPTH; i++) begin
          r_tag[i] <= '0;
        end
      end else begin
        r_pres.vld  <= w_rd_en;
        r_pres.idx  <= r_cnt;
        r_pres.pass <= (r_state == ST_PASS_HI);
        r_tag[0]    <= r_pres;
        for (int i = 1; i < TAG_DEPTH; i++) begin
          r_tag[i] <= r_tag[i-1];
        end
      end
    end
  end

  assign in_ready            = r_ctl.in_rdy;
  assign acc__sel            = r_ctl.acc_sel;
  assign rapx                = r_ctl.rapx;
  assign racc                = r_racc;
  assign state_in_to_wrapper = r_state;
  assign count0              = r_count0;
  assign A_in_to_wrapper     = w_rd_dat[A_W+B_W-1:B_W];
  assign B_in_to_wrapper     = w_rd_dat[B_W-1:0];
  assign res_valid           = r_tag[TAG_DEPTH-1].vld;
  assign res_idx             = r_tag[TAG_DEPTH-1].idx;
  assign res_pass            = r_tag[TAG_DEPTH-1].pass;
  assign res_data            = r_p;
  assign done                = r_done;

endmodule
